// File: rtl/play_session.sv
// rtl/play_session.sv - multi-lane rhythm gameplay session controller
//
// Sequences notes from an external song ROM, lights the target lane, judges
// key hits against perfect/good timing windows and accumulates combo, score
// and per-judgement counters.
//
// Optional build macro: PLAY_SESSION_FAIL_EN ends the session (failed=1) once
// miss_cnt reaches FAIL_LIMIT. Without it, failed stays 0.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   start, pause, abort     session control (start level, pause level, abort pulse)
//   song_len                number of notes, latched on start
//   hit_key                 debounced key levels, one per lane
//   rom_addr/rom_lane/dur   song ROM address out, note lane/duration in
//   lane_led                one-hot target lane
//   state                   0 IDLE 1 COUNTDOWN 2 LOAD 3 PLAY 4 PAUSE 5 DONE
//   combo, max_combo, score current/best combo, accumulated score
//   perfect/good/miss_cnt   judgement counters
//   judge_valid, judge      judgement pulse and type (0 miss 1 good 2 perfect)
//   done, failed            session finished / ended by fail
module play_session #(
  parameter int NUM_LANES       = 7,
  parameter int LANE_W          = 3,
  parameter int ADDR_W          = 8,
  parameter int DUR_W           = 6,
  parameter int CLK_PER_TICK    = 100000,
  parameter int COUNTDOWN_TICKS = 30,
  parameter int PERFECT_WIN     = 2,
  parameter int GOOD_WIN        = 5,
  parameter int PERFECT_PTS     = 300,
  parameter int GOOD_PTS        = 100,
  parameter int COMBO_SHIFT     = 2,
  parameter int SCORE_W         = 24,
  parameter int CNT_W           = 12,
  parameter int FAIL_LIMIT      = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 abort,
  input  logic [ADDR_W-1:0]    song_len,
  input  logic [NUM_LANES-1:0] hit_key,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [LANE_W-1:0]    rom_lane,
  input  logic [DUR_W-1:0]     rom_dur,
  output logic [NUM_LANES-1:0] lane_led,
  output logic [2:0]           state,
  output logic [CNT_W-1:0]     combo,
  output logic [CNT_W-1:0]     max_combo,
  output logic [SCORE_W-1:0]   score,
  output logic [CNT_W-1:0]     perfect_cnt,
  output logic [CNT_W-1:0]     good_cnt,
  output logic [CNT_W-1:0]     miss_cnt,
  output logic                 judge_valid,
  output logic [1:0]           judge,
  output logic                 done,
  output logic                 failed
);

  localparam int TICK_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam int CD_W   = (COUNTDOWN_TICKS > 1) ? $clog2(COUNTDOWN_TICKS + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_COUNTDOWN = 3'd1, S_LOAD = 3'd2,
    S_PLAY = 3'd3, S_PAUSE = 3'd4, S_DONE = 3'd5
  } state_t;

  state_t               st, saved_st;
  logic [TICK_W-1:0]    tick_cnt;
  logic [CD_W-1:0]      cd_cnt;
  logic [NUM_LANES-1:0] hit_key_q;
  logic [LANE_W-1:0]    cur_lane;
  logic [DUR_W-1:0]     cur_dur, age;
  logic                 judged;
  logic [ADDR_W-1:0]    len_q;

  logic [NUM_LANES-1:0] key_rise, target;
  logic [DUR_W-1:0]     eff_dur;
  logic                 tick, note_end, do_judge, fail_now;
  logic [1:0]           jtype;
  logic [CNT_W-1:0]     combo_inc, miss_inc, perfect_inc, good_inc, bonus;
  logic [SCORE_W:0]     score_sum;
  logic [SCORE_W-1:0]   score_new;
  int                   pts;

  assign state    = st;
  assign key_rise = hit_key & ~hit_key_q;
  assign target   = NUM_LANES'(1) << cur_lane;
  // A zero-length note still gets one tick so it can be judged.
  assign eff_dur  = (cur_dur == '0) ? DUR_W'(1) : cur_dur;
  assign tick     = (st == S_COUNTDOWN || st == S_PLAY) && !pause &&
                    (tick_cnt == TICK_W'(CLK_PER_TICK - 1));
  assign note_end = (st == S_PLAY) && (age == eff_dur);

  // Judgement decision; pause and abort both suppress it.
  always_comb begin
    do_judge = 1'b0;
    jtype    = 2'd0;
    if (st == S_PLAY && !judged && !pause && !abort) begin
      if (key_rise != '0) begin
        do_judge = 1'b1;
        if (key_rise == target) begin
          if (int'(age) <= PERFECT_WIN)   jtype = 2'd2;
          else if (int'(age) <= GOOD_WIN) jtype = 2'd1;
        end
      end else if (note_end) begin
        do_judge = 1'b1;
      end
    end
  end

  // Saturating counter/score arithmetic; bonus uses the saturated combo.
  always_comb begin
    combo_inc   = (combo == '1) ? combo : combo + CNT_W'(1);
    miss_inc    = (miss_cnt == '1) ? miss_cnt : miss_cnt + CNT_W'(1);
    perfect_inc = (perfect_cnt == '1) ? perfect_cnt : perfect_cnt + CNT_W'(1);
    good_inc    = (good_cnt == '1) ? good_cnt : good_cnt + CNT_W'(1);
    bonus       = combo_inc >> COMBO_SHIFT;
    pts         = (jtype == 2'd2) ? PERFECT_PTS : GOOD_PTS;
    score_sum   = {1'b0, score} + (SCORE_W+1)'(pts) + (SCORE_W+1)'(bonus);
    score_new   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end

`ifdef PLAY_SESSION_FAIL_EN
  assign fail_now = do_judge && (jtype == 2'd0) && (int'(miss_inc) >= FAIL_LIMIT);
`else
  assign fail_now = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= S_IDLE;        saved_st <= S_IDLE;
      tick_cnt <= '0;      cd_cnt <= '0;        hit_key_q <= '0;
      cur_lane <= '0;      cur_dur <= '0;       age <= '0;
      judged <= 1'b0;      len_q <= '0;         rom_addr <= '0;
      lane_led <= '0;      combo <= '0;         max_combo <= '0;
      score <= '0;         perfect_cnt <= '0;   good_cnt <= '0;
      miss_cnt <= '0;      judge_valid <= 1'b0; judge <= 2'd0;
      done <= 1'b0;        failed <= 1'b0;
    end else begin
      hit_key_q   <= hit_key;
      judge_valid <= 1'b0;

      // Divider is re-zeroed at each note load so every note's age 0 is a full tick.
      if (st == S_IDLE || st == S_LOAD)
        tick_cnt <= '0;
      else if ((st == S_COUNTDOWN || st == S_PLAY) && !pause)
        tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);

      if (do_judge) begin
        judge_valid <= 1'b1;
        judge       <= jtype;
        judged      <= 1'b1;
        if (jtype == 2'd0) begin
          combo    <= '0;
          miss_cnt <= miss_inc;
        end else begin
          combo <= combo_inc;
          score <= score_new;
          if (combo_inc > max_combo) max_combo <= combo_inc;
          if (jtype == 2'd2) perfect_cnt <= perfect_inc;
          else               good_cnt    <= good_inc;
        end
      end

      if (abort && st != S_IDLE && st != S_DONE) begin
        st       <= S_DONE;
        done     <= 1'b1;
        lane_led <= '0;
      end else begin
        case (st)
          S_IDLE: begin
            if (start) begin
              len_q <= song_len;   rom_addr <= '0;    cd_cnt <= '0;
              combo <= '0;         max_combo <= '0;   score <= '0;
              perfect_cnt <= '0;   good_cnt <= '0;    miss_cnt <= '0;
              failed <= 1'b0;
              st <= S_COUNTDOWN;
            end
          end
          S_COUNTDOWN: begin
            if (pause) begin
              saved_st <= S_COUNTDOWN;
              st       <= S_PAUSE;
            end else if (tick) begin
              if (int'(cd_cnt) >= COUNTDOWN_TICKS - 1) begin
                if (len_q == '0) begin
                  st   <= S_DONE;
                  done <= 1'b1;
                end else begin
                  st <= S_LOAD;
                end
              end else begin
                cd_cnt <= cd_cnt + CD_W'(1);
              end
            end
          end
          S_LOAD: begin
            cur_lane <= rom_lane;
            cur_dur  <= rom_dur;
            lane_led <= NUM_LANES'(1) << rom_lane;
            age      <= '0;
            judged   <= 1'b0;
            st       <= S_PLAY;
          end
          S_PLAY: begin
            if (pause) begin
              saved_st <= S_PLAY;
              st       <= S_PAUSE;
              lane_led <= '0;
            end else if (fail_now) begin
              failed   <= 1'b1;
              done     <= 1'b1;
              lane_led <= '0;
              st       <= S_DONE;
            end else if (note_end) begin
              lane_led <= '0;
              if (({1'b0, rom_addr} + (ADDR_W+1)'(1)) < {1'b0, len_q}) begin
                rom_addr <= rom_addr + ADDR_W'(1);
                st       <= S_LOAD;
              end else begin
                done <= 1'b1;
                st   <= S_DONE;
              end
            end else if (tick) begin
              age <= age + DUR_W'(1);
              // LED goes dark in the note-end cycle, which follows this tick.
              if (age + DUR_W'(1) == eff_dur) lane_led <= '0;
            end
          end
          S_PAUSE: begin
            if (!pause) begin
              st <= saved_st;
              if (saved_st == S_PLAY && age != eff_dur) lane_led <= target;
            end
          end
          S_DONE: begin
            lane_led <= '0;
            if (!start) begin
              done <= 1'b0;
              st   <= S_IDLE;
            end
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_play_session.sv
// tb/tb_play_session.sv - scoreboard testbench for play_session
module tb_play_session;

  logic        clk = 1'b0;
  logic        rst_n, start, pause, abort;
  logic [7:0]  song_len, rom_addr;
  logic [6:0]  hit_key, lane_led;
  logic [2:0]  rom_lane, state;
  logic [5:0]  rom_dur;
  logic [11:0] combo, max_combo, perfect_cnt, good_cnt, miss_cnt;
  logic [23:0] score;
  logic        judge_valid, done, failed;
  logic [1:0]  judge;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]  j;
    logic [11:0] combo;
    logic [23:0] score;
  } exp_t;
  exp_t exp_q[$];

  int m_combo, m_max, m_score, m_perf, m_good, m_miss;

  always #5 clk = ~clk;

  play_session #(.CLK_PER_TICK(4), .COUNTDOWN_TICKS(2), .FAIL_LIMIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .abort(abort),
    .song_len(song_len), .hit_key(hit_key), .rom_addr(rom_addr),
    .rom_lane(rom_lane), .rom_dur(rom_dur), .lane_led(lane_led), .state(state),
    .combo(combo), .max_combo(max_combo), .score(score),
    .perfect_cnt(perfect_cnt), .good_cnt(good_cnt), .miss_cnt(miss_cnt),
    .judge_valid(judge_valid), .judge(judge), .done(done), .failed(failed)
  );

  // Song ROM: (lane2,dur8), (lane0,dur8), (lane6,dur8)
  always_comb begin
    rom_lane = 3'd0;
    rom_dur  = 6'd8;
    case (rom_addr)
      8'd0: rom_lane = 3'd2;
      8'd1: rom_lane = 3'd0;
      8'd2: rom_lane = 3'd6;
      default: rom_lane = 3'd0;
    endcase
  end

  // Scoreboard consumer: every judgement pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && judge_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_judge: got judge=%0d, expected none", judge);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (judge !== e.j) begin
          errors++;
          $display("FAIL judge_type: got %0d expected %0d", judge, e.j);
        end
        checks++;
        if (combo !== e.combo) begin
          errors++;
          $display("FAIL judge_combo: got %0d expected %0d", combo, e.combo);
        end
        checks++;
        if (score !== e.score) begin
          errors++;
          $display("FAIL judge_score: got %0d expected %0d", score, e.score);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_judge(input logic [1:0] j);
    exp_t e;
    if (j != 2'd0) begin
      m_combo++;
      if (m_combo > m_max) m_max = m_combo;
      m_score += ((j == 2'd2) ? 300 : 100) + (m_combo >> 2);
      if (j == 2'd2) m_perf++; else m_good++;
    end else begin
      m_combo = 0;
      m_miss++;
    end
    e.j = j;
    e.combo = 12'(m_combo);
    e.score = 24'(m_score);
    exp_q.push_back(e);
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (state !== s && n < limit);
    checks++;
    if (state !== s) begin
      errors++;
      $display("FAIL %s: state=%0d, expected %0d within %0d cycles", name, state, s, limit);
    end
  endtask

  task automatic wait_leave_play(input string name);
    int n = 0;
    while (state === 3'd3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (state === 3'd3) begin
      errors++;
      $display("FAIL %s: note never ended", name);
    end
  endtask

  task automatic start_session(input logic [7:0] len);
    m_combo = 0; m_max = 0; m_score = 0; m_perf = 0; m_good = 0; m_miss = 0;
    exp_q.delete();
    song_len = len;
    start = 1'b1;
  endtask

  // press_age < 0 means no press: the note expires as a miss.
  task automatic run_note(input int press_age, input logic [6:0] keys, input int lane);
    logic [6:0] tgt;
    logic [1:0] j;
    tgt = 7'(1 << lane);
    wait_state(3'd3, 200, "enter_play");
    checks++;
    if (lane_led !== tgt) begin
      errors++;
      $display("FAIL lane_led: got %b expected %b", lane_led, tgt);
    end
    if (press_age >= 0) begin
      repeat (4 * press_age + 1) @(negedge clk);
      hit_key = keys;
      if (keys == tgt) j = (press_age <= 2) ? 2'd2 : (press_age <= 5) ? 2'd1 : 2'd0;
      else             j = 2'd0;
      push_judge(j);
      @(negedge clk);
      hit_key = '0;
    end else begin
      push_judge(2'd0);
    end
    wait_leave_play("note_end");
  endtask

  task automatic end_session(input string name);
    logic exp_failed;
`ifdef PLAY_SESSION_FAIL_EN
    exp_failed = (m_miss >= 2);
`else
    exp_failed = 1'b0;
`endif
    wait_state(3'd5, 200, "reach_done");
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || lane_led !== 7'd0 || failed !== exp_failed) begin
      errors++;
      $display("FAIL %s_done: done=%b lane_led=%b failed=%b expected 1,0,%b", name, done, lane_led, failed, exp_failed);
    end
    checks++;
    if (combo !== 12'(m_combo) || max_combo !== 12'(m_max) || score !== 24'(m_score)) begin
      errors++;
      $display("FAIL %s_totals: combo=%0d max=%0d score=%0d expected %0d %0d %0d", name, combo, max_combo, score, m_combo, m_max, m_score);
    end
    checks++;
    if (perfect_cnt !== 12'(m_perf) || good_cnt !== 12'(m_good) || miss_cnt !== 12'(m_miss)) begin
      errors++;
      $display("FAIL %s_counts: p=%0d g=%0d m=%0d expected %0d %0d %0d", name, perfect_cnt, good_cnt, miss_cnt, m_perf, m_good, m_miss);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: %0d judgements never produced, expected 0", name, exp_q.size());
    end
  endtask

  task automatic close_session(input string name);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: state=%0d done=%b expected 0,0", name, state, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; pause = 0; abort = 0; song_len = 0; hit_key = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rom_addr, lane_led, state, combo, max_combo, score, perfect_cnt, good_cnt,
         miss_cnt, judge_valid, judge, done, failed} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: state=%0d score=%0d lane_led=%b rom_addr=%0d expected all 0", state, score, lane_led, rom_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clean_run();
    start_session(8'd3);
    run_note(1, 7'b0000100, 2);
    run_note(1, 7'b0000001, 0);
    run_note(1, 7'b1000000, 6);
    end_session("clean");
    checks++;
    if (score !== 24'd900 || perfect_cnt !== 12'd3 || max_combo !== 12'd3) begin
      errors++;
      $display("FAIL clean_literal: score=%0d perfect=%0d max=%0d expected 900 3 3", score, perfect_cnt, max_combo);
    end
    close_session("clean");
  endtask

  task automatic test_windows();
    start_session(8'd3);
    run_note(4, 7'b0000100, 2);
    run_note(7, 7'b0000001, 0);
    run_note(-1, 7'b0000000, 6);
    end_session("windows");
    checks++;
    if (score !== 24'd100 || good_cnt !== 12'd1 || miss_cnt !== 12'd2 || combo !== 12'd0) begin
      errors++;
      $display("FAIL windows_literal: score=%0d good=%0d miss=%0d combo=%0d expected 100 1 2 0", score, good_cnt, miss_cnt, combo);
    end
    close_session("windows");
  endtask

  task automatic test_empty_song();
    int n = 0;
    logic saw_load = 1'b0;
    start_session(8'd0);
    do begin
      @(negedge clk);
      n++;
      if (state === 3'd2 || state === 3'd3) saw_load = 1'b1;
    end while (state !== 3'd5 && n < 100);
    checks++;
    if (n != 9 || saw_load) begin
      errors++;
      $display("FAIL empty_timing: reached state %0d after %0d cycles (load=%b), expected DONE after 9, no load", state, n, saw_load);
    end
    checks++;
    if (score !== 0 || perfect_cnt !== 0 || good_cnt !== 0 || miss_cnt !== 0 || max_combo !== 0 || done !== 1'b1) begin
      errors++;
      $display("FAIL empty_counts: score=%0d p=%0d g=%0d m=%0d done=%b expected zeros, done 1", score, perfect_cnt, good_cnt, miss_cnt, done);
    end
    close_session("empty");
  endtask

  task automatic test_wrong_lane();
    start_session(8'd3);
    run_note(1, 7'b0000101, 2);
    run_note(0, 7'b0000001, 0);
    run_note(1, 7'b1000000, 6);
    end_session("wrong");
    close_session("wrong");
  endtask

  task automatic test_pause();
    start_session(8'd3);
    wait_state(3'd3, 200, "pause_enter_play");
    repeat (13) @(negedge clk);
    pause = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd4 || lane_led !== 7'd0) begin
      errors++;
      $display("FAIL pause_state: state=%0d lane_led=%b expected 4, 0", state, lane_led);
    end
    repeat (10) @(negedge clk);
    hit_key = 7'b0000001;
    repeat (5) @(negedge clk);
    hit_key = 7'b0000000;
    repeat (34) @(negedge clk);
    pause = 1'b0;
    wait_state(3'd3, 5, "pause_resume");
    checks++;
    if (lane_led !== 7'b0000100) begin
      errors++;
      $display("FAIL pause_led_restore: got %b expected 0000100", lane_led);
    end
    repeat (4) @(negedge clk);
    hit_key = 7'b0000100;
    push_judge(2'd1);
    @(negedge clk);
    hit_key = '0;
    wait_leave_play("pause_note_end");
    run_note(1, 7'b0000001, 0);
    run_note(1, 7'b1000000, 6);
    end_session("pause");
    close_session("pause");
  endtask

  task automatic test_abort();
    start_session(8'd3);
    run_note(1, 7'b0000100, 2);
    wait_state(3'd3, 200, "abort_enter_play");
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (state !== 3'd5 || done !== 1'b1 || miss_cnt !== 0 || score !== 24'd300 || combo !== 12'd1) begin
      errors++;
      $display("FAIL abort: state=%0d done=%b miss=%0d score=%0d combo=%0d expected 5 1 0 300 1", state, done, miss_cnt, score, combo);
    end
    close_session("abort");
  endtask

  task automatic test_reset_in_play();
    start_session(8'd3);
    run_note(1, 7'b0000100, 2);
    wait_state(3'd3, 200, "rst_enter_play");
    checks++;
    if (score !== 24'd300) begin
      errors++;
      $display("FAIL rst_pre_score: got %0d expected 300", score);
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || score !== 0 || lane_led !== 0 || rom_addr !== 0 || combo !== 0 || done !== 0) begin
      errors++;
      $display("FAIL rst_in_play: state=%0d score=%0d led=%b addr=%0d combo=%0d expected all 0", state, score, lane_led, rom_addr, combo);
    end
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
  endtask

`ifdef PLAY_SESSION_FAIL_EN
  task automatic test_fail_limit();
    start_session(8'd3);
    run_note(-1, 7'b0000000, 2);
    run_note(-1, 7'b0000000, 0);
    end_session("fail");
    checks++;
    if (failed !== 1'b1 || rom_addr !== 8'd1) begin
      errors++;
      $display("FAIL fail_limit: failed=%b rom_addr=%0d expected 1, 1", failed, rom_addr);
    end
    close_session("fail");
  endtask
`endif

  initial begin
    test_reset();
    test_clean_run();
`ifndef PLAY_SESSION_FAIL_EN
    test_windows();
`endif
    test_empty_song();
    test_wrong_lane();
    test_pause();
    test_abort();
    test_reset_in_play();
`ifdef PLAY_SESSION_FAIL_EN
    test_fail_limit();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
